tag_resolver: RTL
=================

# tag_resolver

- Sits directly downstream of the cell array.
- Captures the per-row match vector (`tag_row`) produced by a compare pass into a tag register.
- Feeds that register back to the array's `tag` write-enable input for the following write pass.
- Can enumerate the matched rows one at a time as row addresses, via a valid/ready handshake, so a controller can drive `addr_output_Row` for readout.

## Interface
Parameters:
- `DATA_DEPTH`, 16, number of rows; width of the tag vector.
- `ADDR_WIDTH_CAM`, 8, width of a row address; requires `DATA_DEPTH` ≤ 2^`ADDR_WIDTH_CAM`.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rstIn`  in  1  reset: one clock; asynchronous, active-low.
- `tag_row`  in  `DATA_DEPTH`  match vector from the cell array; bit i = row i matched.
- `cmp_valid`  in  1  sample `tag_row` this edge.
- `acc_op`  in  2  combine mode for the capture: 00 load, 01 OR, 10 AND, 11 AND-NOT. Present only with `TAG_ACCUM_EN`.
- `clr_tag`  in  1  clear the tag register.
- `tag`  out  `DATA_DEPTH`  registered tag vector, driven to the array's `tag` input.
- `any_match`  out  1  OR-reduction of `tag`.
- `match_count`  out  `ADDR_WIDTH_CAM`+1  population count of `tag`.
- `enum_start`  in  1  begin enumerating the set bits of `tag`.
- `enum_valid`  out  1  `enum_addr` holds a matched row.
- `enum_ready`  in  1  consumer accepts `enum_addr`.
- `enum_addr`  out  `ADDR_WIDTH_CAM`  row index being offered.
- `enum_last`  out  1  offered row is the final set bit.
- `busy`  out  1  enumeration in progress.

## Operation
State machine, two states: IDLE and ENUM.

IDLE:
- Command priority: `clr_tag` > `cmp_valid` > `enum_start`. Only the highest-priority asserted command acts; the others are dropped that cycle.
- `clr_tag`: `tag` ← 0.
- `cmp_valid` with `TAG_ACCUM_EN`:
  - load: `tag` ← `tag_row`
  - OR: `tag` ← `tag` | `tag_row`
  - AND: `tag` ← `tag` & `tag_row`
  - AND-NOT: `tag` ← `tag` & ~`tag_row`
- `cmp_valid` without `TAG_ACCUM_EN`: always load.
- `enum_start` with `tag` ≠ 0:
  - Copy `tag` into an internal pending vector.
  - Go to ENUM.
  - `enum_addr` ← index of the lowest set bit.
  - `enum_last` ← 1 when exactly one bit is set.
- `enum_start` with `tag` = 0: stay in IDLE; `enum_valid` never rises.

ENUM:
- `busy` = 1 and `enum_valid` = 1 throughout.
- `tag` is frozen; `cmp_valid`, `clr_tag` and `enum_start` are ignored.
- On `enum_valid` & `enum_ready`:
  - Clear the offered bit in the pending vector.
  - If `enum_last` was 1, return to IDLE.
  - Otherwise load `enum_addr` and `enum_last` for the next-lowest set bit.
- While `enum_ready` = 0, `enum_addr` and `enum_last` hold stable.

Outputs and widths:
- `any_match` and `match_count` are always consistent with the current `tag`.
- `match_count` reaches `DATA_DEPTH` when all rows match, with no overflow.
- Priority encoding: lowest index first. Ascending order is guaranteed.

## Timing
- Reset value of every output is 0: `tag`, `any_match`, `match_count`, `enum_valid`, `enum_addr`, `enum_last`, `busy`. The state machine resets to IDLE and the pending vector to 0.
- Asserting `rstIn` mid-ENUM aborts immediately; the partial enumeration is lost.
- Capture latency: `cmp_valid` at edge N → new `tag`, `any_match` and `match_count` visible after edge N.
- Enumeration start: `enum_start` at edge N → `enum_valid` = 1 after edge N.
- Throughput: one address per cycle when `enum_ready` is held high.
- Exit: the handshake on the last address at edge M → `enum_valid` = 0 and `busy` = 0 after M. A new command is accepted at edge M+1.
- `enum_valid` never drops without a completed handshake, except on reset.

## Configuration
- Macro: `TAG_ACCUM_EN`.
- Defined: the `acc_op` port exists and all four combine modes are supported, enabling multi-pass associative compares.
- Undefined: the `acc_op` port is removed and every `cmp_valid` performs a plain load.
- Enumeration behaviour is identical in both builds.

## Test plan
- Reset and load: reset, then `cmp_valid` with `tag_row`=16'h0000 → `tag`=0, `any_match`=0, `match_count`=0. Then `cmp_valid` with `tag_row`=16'h8421 → `tag`=16'h8421, `any_match`=1, `match_count`=4.
- Enumeration, ready held: `tag`=16'h8421, `enum_start`, `enum_ready`=1 → `enum_addr` 0, 5, 10, 15 on consecutive cycles; `enum_last` high only with 15; `busy` low the cycle after.
- Backpressure and frozen tag: `tag`=16'h0006, `enum_ready` low for 3 cycles → `enum_addr`=1 held stable. Then addr 2 with `enum_last`=1. `cmp_valid` and `clr_tag` during ENUM leave `tag` unchanged.
- Empty and all-ones: `enum_start` with `tag`=0 → `enum_valid` stays 0. `tag`=16'hFFFF → `match_count`=16; enumeration yields 0..15.
- Accumulate modes (`TAG_ACCUM_EN`): load 16'h00F0, then OR 16'h0F00 → 16'h0FF0; AND 16'h0330 → 16'h0330; AND-NOT 16'h0030 → 16'h0300. Priority check: `clr_tag` together with `cmp_valid` → `tag`=0.
- Reset mid-enumeration: drop `rstIn` during ENUM → every output is 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/tag_resolver_if.sv
// Bundle between the compare-pass controller and tag_resolver.
// The acc_op field exists only when TAG_ACCUM_EN is defined.
interface tag_resolver_if #(
  parameter int DATA_DEPTH     = 16,
  parameter int ADDR_WIDTH_CAM = 8
);
  logic [DATA_DEPTH-1:0]     tag_row;
  logic                      cmp_valid;
`ifdef TAG_ACCUM_EN
  logic [1:0]                acc_op;
`endif
  logic                      clr_tag;
  logic [DATA_DEPTH-1:0]     tag;
  logic                      any_match;
  logic [ADDR_WIDTH_CAM:0]   match_count;
  logic                      enum_start;
  logic                      enum_valid;
  logic                      enum_ready;
  logic [ADDR_WIDTH_CAM-1:0] enum_addr;
  logic                      enum_last;
  logic                      busy;

  modport master (
    output tag_row, cmp_valid,
`ifdef TAG_ACCUM_EN
    output acc_op,
`endif
    output clr_tag, enum_start, enum_ready,
    input  tag, any_match, match_count, enum_valid, enum_addr, enum_last, busy
  );

  modport slave (
    input  tag_row, cmp_valid,
`ifdef TAG_ACCUM_EN
    input  acc_op,
`endif
    input  clr_tag, enum_start, enum_ready,
    output tag, any_match, match_count, enum_valid, enum_addr, enum_last, busy
  );
endinterface

// File: rtl/tag_resolver.sv
// Captures the cell-array match vector into a tag register and enumerates its set bits
// lowest-first over a valid/ready handshake. TAG_ACCUM_EN adds OR/AND/AND-NOT capture modes.
module tag_resolver #(
  parameter int DATA_DEPTH     = 16,
  parameter int ADDR_WIDTH_CAM = 8
) (
  input logic           clk,
  input logic           rstIn,
  tag_resolver_if.slave bus
);

  typedef enum logic {IDLE, ENUM} state_t;

  state_t                    state_reg, state_next;
  logic [DATA_DEPTH-1:0]     tag_reg, tag_next;
  logic [DATA_DEPTH-1:0]     pending_reg, pending_next;
  logic [ADDR_WIDTH_CAM-1:0] enum_addr_reg, enum_addr_next;
  logic                      enum_last_reg, enum_last_next;

  logic [DATA_DEPTH-1:0]     offered_mask;
  logic [DATA_DEPTH-1:0]     scan_vec;
  logic [ADDR_WIDTH_CAM-1:0] scan_addr;
  logic                      scan_single;
  logic [ADDR_WIDTH_CAM:0]   pop_count;

  genvar gi;
  generate
    for (gi = 0; gi < DATA_DEPTH; gi++) begin : g_offered
      assign offered_mask[gi] = (enum_addr_reg == ADDR_WIDTH_CAM'(gi));
    end
  endgenerate

  // One shared priority encoder: scans the tag when starting, or the pending
  // vector with the currently offered bit already removed when advancing.
  assign scan_vec    = (state_reg == IDLE) ? tag_reg : (pending_reg & ~offered_mask);
  assign scan_single = (scan_vec != '0) && ((scan_vec & (scan_vec - DATA_DEPTH'(1))) == '0);

  always_comb begin
    scan_addr = '0;
    for (int i = DATA_DEPTH - 1; i >= 0; i--) begin
      if (scan_vec[i]) scan_addr = ADDR_WIDTH_CAM'(i);
    end
  end

  always_comb begin
    pop_count = '0;
    for (int i = 0; i < DATA_DEPTH; i++) begin
      pop_count = pop_count + (ADDR_WIDTH_CAM + 1)'(tag_reg[i]);
    end
  end

  always_comb begin
    state_next     = state_reg;
    tag_next       = tag_reg;
    pending_next   = pending_reg;
    enum_addr_next = enum_addr_reg;
    enum_last_next = enum_last_reg;
    case (state_reg)
      IDLE: begin
        if (bus.clr_tag) begin
          tag_next = '0;
        end else if (bus.cmp_valid) begin
`ifdef TAG_ACCUM_EN
          case (bus.acc_op)
            2'b00:   tag_next = bus.tag_row;
            2'b01:   tag_next = tag_reg | bus.tag_row;
            2'b10:   tag_next = tag_reg & bus.tag_row;
            default: tag_next = tag_reg & ~bus.tag_row;
          endcase
`else
          tag_next = bus.tag_row;
`endif
        end else if (bus.enum_start && (tag_reg != '0)) begin
          pending_next   = tag_reg;
          enum_addr_next = scan_addr;
          enum_last_next = scan_single;
          state_next     = ENUM;
        end
      end
      ENUM: begin
        if (bus.enum_ready) begin
          pending_next = scan_vec;
          if (enum_last_reg) begin
            enum_addr_next = '0;
            enum_last_next = 1'b0;
            state_next     = IDLE;
          end else begin
            enum_addr_next = scan_addr;
            enum_last_next = scan_single;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstIn) begin
    if (!rstIn) begin
      state_reg     <= IDLE;
      tag_reg       <= '0;
      pending_reg   <= '0;
      enum_addr_reg <= '0;
      enum_last_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      tag_reg       <= tag_next;
      pending_reg   <= pending_next;
      enum_addr_reg <= enum_addr_next;
      enum_last_reg <= enum_last_next;
    end
  end

  assign bus.tag         = tag_reg;
  assign bus.any_match   = |tag_reg;
  assign bus.match_count = pop_count;
  assign bus.enum_valid  = (state_reg == ENUM);
  assign bus.busy        = (state_reg == ENUM);
  assign bus.enum_addr   = enum_addr_reg;
  assign bus.enum_last   = enum_last_reg;

endmodule
